vga_timing_generator: RTL and testbench

- Produces the pixel-coordinate and sync stream consumed by the image generator: 1-based active coordinates, hsync/vsync, active flag and a pixel strobe for 640x480@60 from the 100 MHz board clock.
- Sits between the top level and the image generator; its coordinates drive the image generator's x/y inputs, and its syncs go to the VGA connector.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_generator.sv | 138 +++++++++++++
 tb/tb_vga_timing_generator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, coordinate widths and the per-axis phase type
// for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned VGA_CLK_DIV  = 4;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned X_MAX = (1 << X_W) - 1;
  localparam int unsigned Y_MAX = (1 << Y_W) - 1;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

  // Full-scale or dark level for one test-pattern colour channel.
  function automatic logic [3:0] tp_level(input logic on);
    return on ? 4'hF : 4'h0;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter plus phase FSM.
// count_c/phase_c are the values loaded at this edge so the parent can register aligned outputs.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN      = 640,
  parameter int unsigned FP_LEN          = 16,
  parameter int unsigned SYNC_LEN        = 96,
  parameter int unsigned BP_LEN          = 48,
  parameter int unsigned CNT_W           = 11,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count_c,
  output phase_e           phase_c,
  output logic             sync,
  output logic             wrap_c
);

  localparam int unsigned TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;
  localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(ACTIVE_LEN);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE_LEN + FP_LEN);
  localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);
  localparam logic             SYNC_ON     = ~SYNC_ACTIVE_LOW;

  logic [CNT_W-1:0] count;
  phase_e           phase;

  // Next position and phase; the phase changes on the step into its first count.
  always_comb begin
    count_c = count;
    phase_c = phase;
    wrap_c  = 1'b0;
    if (en) begin
      if (count == LAST) begin
        count_c = '0;
        wrap_c  = 1'b1;
      end else begin
        count_c = count + CNT_W'(1);
      end
      case (phase)
        PH_ACTIVE: if (count_c == FRONT_START) phase_c = PH_FRONT;
        PH_FRONT:  if (count_c == SYNC_START)  phase_c = PH_SYNC;
        PH_SYNC:   if (count_c == BACK_START)  phase_c = PH_BACK;
        PH_BACK:   if (count_c == '0)          phase_c = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count <= LAST;
      phase <= PH_BACK;
      sync  <= ~SYNC_ON;
    end else if (en) begin
      count <= count_c;
      phase <= phase_c;
      sync  <= (phase_c == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA pixel-coordinate / sync generator with a clock-divided pixel strobe.
// Define VGA_TESTPAT_EN to add an 8-bar colour test pattern on o_tp_red/green/blue.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV         = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE        = VGA_H_ACTIVE,
  parameter int unsigned H_FP            = VGA_H_FP,
  parameter int unsigned H_SYNC          = VGA_H_SYNC,
  parameter int unsigned H_BP            = VGA_H_BP,
  parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
  parameter int unsigned V_FP            = VGA_V_FP,
  parameter int unsigned V_SYNC          = VGA_V_SYNC,
  parameter int unsigned V_BP            = VGA_V_BP,
  parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_active,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_pix_stb,
  output logic           o_frame_start
`ifdef VGA_TESTPAT_EN
  ,
  output logic [3:0]     o_tp_red,
  output logic [3:0]     o_tp_green,
  output logic [3:0]     o_tp_blue
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam bit          SYNC_LOW = (SYNC_ACTIVE_LOW != 0);

  if (CLK_DIV < 1) begin : g_div_check
    $error("CLK_DIV must be at least 1");
  end
  if (H_TOTAL > X_MAX) begin : g_h_check
    $error("H_TOTAL does not fit the x coordinate width");
  end
  if (V_TOTAL > Y_MAX) begin : g_v_check
    $error("V_TOTAL does not fit the y coordinate width");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             stb_c;
  logic [X_W-1:0]   h_cnt_c;
  logic [Y_W-1:0]   v_cnt_c;
  phase_e           h_phase_c;
  phase_e           v_phase_c;
  logic             h_wrap_c;
  logic             v_wrap_c;
  logic             vis_c;

  assign stb_c = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign vis_c = (h_phase_c == PH_ACTIVE) && (v_phase_c == PH_ACTIVE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) div_cnt <= '0;
    else          div_cnt <= stb_c ? '0 : div_cnt + DIV_W'(1);
  end

  vga_axis_counter #(
    .ACTIVE_LEN     (H_ACTIVE),
    .FP_LEN         (H_FP),
    .SYNC_LEN       (H_SYNC),
    .BP_LEN         (H_BP),
    .CNT_W          (X_W),
    .SYNC_ACTIVE_LOW(SYNC_LOW)
  ) u_h_axis (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .en     (stb_c),
    .count_c(h_cnt_c),
    .phase_c(h_phase_c),
    .sync   (o_hsync),
    .wrap_c (h_wrap_c)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE_LEN     (V_ACTIVE),
    .FP_LEN         (V_FP),
    .SYNC_LEN       (V_SYNC),
    .BP_LEN         (V_BP),
    .CNT_W          (Y_W),
    .SYNC_ACTIVE_LOW(SYNC_LOW)
  ) u_v_axis (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .en     (h_wrap_c),
    .count_c(v_cnt_c),
    .phase_c(v_phase_c),
    .sync   (o_vsync),
    .wrap_c (v_wrap_c)
  );

`ifdef VGA_TESTPAT_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_c;
  assign bar_c = 3'(h_cnt_c / X_W'(BAR_W));
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_pix_stb <= 1'b0;
    else          o_pix_stb <= stb_c;
  end

  // Coordinates track the counters loaded at the same strobe edge; a vertical wrap is (0,0).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_x           <= '0;
      o_y           <= '0;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
`ifdef VGA_TESTPAT_EN
      o_tp_red      <= 4'h0;
      o_tp_green    <= 4'h0;
      o_tp_blue     <= 4'h0;
`endif
    end else if (stb_c) begin
      o_x           <= vis_c ? (h_cnt_c + X_W'(1)) : '0;
      o_y           <= (v_phase_c == PH_ACTIVE) ? (v_cnt_c + Y_W'(1)) : '0;
      o_active      <= vis_c;
      o_frame_start <= v_wrap_c;
`ifdef VGA_TESTPAT_EN
      o_tp_red      <= tp_level(vis_c & bar_c[2]);
      o_tp_green    <= tp_level(vis_c & bar_c[1]);
      o_tp_blue     <= tp_level(vis_c & bar_c[0]);
`endif
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: default timing, a reduced-size frame and a
// CLK_DIV=1 active-high-sync build, each traced against an independent position model.
module tb_vga_timing_generator;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        act;
    logic        hs;
    logic        vs;
    logic        stb;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  logic [10:0] d_x, s_x, f_x;
  logic [9:0]  d_y, s_y, f_y;
  logic        d_act, d_hs, d_vs, d_stb, d_fs;
  logic        s_act, s_hs, s_vs, s_stb, s_fs;
  logic        f_act, f_hs, f_vs, f_stb, f_fs;
  logic [11:0] d_rgb, s_rgb, f_rgb;

`ifdef VGA_TESTPAT_EN
  logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b, f_r, f_g, f_b;
  assign d_rgb = {d_r, d_g, d_b};
  assign s_rgb = {s_r, s_g, s_b};
  assign f_rgb = {f_r, f_g, f_b};
`else
  assign d_rgb = 12'h000;
  assign s_rgb = 12'h000;
  assign f_rgb = 12'h000;
`endif

  obs_t od, os, of;
  assign od = {d_x, d_y, d_act, d_hs, d_vs, d_stb, d_fs, d_rgb};
  assign os = {s_x, s_y, s_act, s_hs, s_vs, s_stb, s_fs, s_rgb};
  assign of = {f_x, f_y, f_act, f_hs, f_vs, f_stb, f_fs, f_rgb};

  // Default 640x480 timing, CLK_DIV 4, active-low syncs.
  vga_timing_generator u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(d_x), .o_y(d_y), .o_active(d_act),
    .o_hsync(d_hs), .o_vsync(d_vs), .o_pix_stb(d_stb), .o_frame_start(d_fs)
`ifdef VGA_TESTPAT_EN
    , .o_tp_red(d_r), .o_tp_green(d_g), .o_tp_blue(d_b)
`endif
  );

  // Small 24x13 frame so whole frames fit in a short run.
  vga_timing_generator #(
    .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_ACTIVE_LOW(1)
  ) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(s_x), .o_y(s_y), .o_active(s_act),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_pix_stb(s_stb), .o_frame_start(s_fs)
`ifdef VGA_TESTPAT_EN
    , .o_tp_red(s_r), .o_tp_green(s_g), .o_tp_blue(s_b)
`endif
  );

  // Undivided clock, default line timing, short frame, active-high syncs.
  vga_timing_generator #(
    .CLK_DIV(1), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_ACTIVE_LOW(0)
  ) u_fast (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(f_x), .o_y(f_y), .o_active(f_act),
    .o_hsync(f_hs), .o_vsync(f_vs), .o_pix_stb(f_stb), .o_frame_start(f_fs)
`ifdef VGA_TESTPAT_EN
    , .o_tp_red(f_r), .o_tp_green(f_g), .o_tp_blue(f_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs e clocks after reset release (e = 0 is the reset state).
  function automatic obs_t model(input int ev, input int div, input int ha, input int hf,
                                 input int hsw, input int hb, input int va, input int vf,
                                 input int vsw, input int vb, input bit low);
    obs_t m;
    int ht, vt, p, h, v;
    logic [2:0] bar;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    m = '0;
    m.hs = low;
    m.vs = low;
    if (ev < div) return m;
    p = ev / div - 1;
    h = p % ht;
    v = (p / ht) % vt;
    m.stb = (ev % div == 0);
    m.act = (h < ha) && (v < va);
    m.x = m.act ? 11'(h + 1) : 11'd0;
    m.y = (v < va) ? 10'(v + 1) : 10'd0;
    m.fs = (h == 0) && (v == 0);
    m.hs = (h >= ha + hf && h < ha + hf + hsw) ? ~low : low;
    m.vs = (v >= va + vf && v < va + vf + vsw) ? ~low : low;
`ifdef VGA_TESTPAT_EN
    if (m.act) begin
      bar = 3'(h / (ha / 8));
      m.rgb = {bar[2] ? 4'hF : 4'h0, bar[1] ? 4'hF : 4'h0, bar[0] ? 4'hF : 4'h0};
    end
`endif
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_trace(input int n, input int run);
    bit d_ok = 1, s_ok = 1, f_ok = 1;
    int f0, d_hs_low = 0, d_stb_n = 0, f_hs_high = 0, f_stb_n = 0, s_vs_low = 0;
    int s_last = 0, f_last = 0;
    logic s_fs_prev = 1'b0, f_fs_prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      f0 = n_fail;
      if (d_ok) check($sformatf("dut_trace e=%0d", e), 64'(od),
                      64'(model(e, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1)));
      if (n_fail != f0) d_ok = 0;
      f0 = n_fail;
      if (s_ok) check($sformatf("small_trace e=%0d", e), 64'(os),
                      64'(model(e, 4, 16, 2, 3, 3, 8, 1, 2, 2, 1'b1)));
      if (n_fail != f0) s_ok = 0;
      f0 = n_fail;
      if (f_ok) check($sformatf("fast_trace e=%0d", e), 64'(of),
                      64'(model(e, 1, 640, 16, 96, 48, 8, 1, 2, 2, 1'b0)));
      if (n_fail != f0) f_ok = 0;

      if (e >= 4 && e <= 3203 && d_hs == 1'b0) d_hs_low++;
      if (e >= 4 && e <= 3203 && d_stb) d_stb_n++;
      if (e <= 3200 && f_hs == 1'b1) f_hs_high++;
      if (f_stb) f_stb_n++;
      if (e >= 4 && e <= 1251 && s_vs == 1'b0) s_vs_low++;

      if (s_fs && !s_fs_prev) begin
        if (s_last > 0) check("small_frame_len", 64'(e - s_last), 64'd1248);
        s_last = e;
      end
      if (f_fs && !f_fs_prev) begin
        if (f_last > 0) check("fast_frame_len", 64'(e - f_last), 64'd10400);
        f_last = e;
      end
      s_fs_prev = s_fs;
      f_fs_prev = f_fs;

      if (e == 3) check("stb_before_first", 64'({d_stb, s_stb}), 64'd0);
      if (e == 4) begin
        check("first_stb",  64'({d_stb, s_stb}), 64'b11);
        check("first_x",    64'(d_x), 64'd1);
        check("first_y",    64'(d_y), 64'd1);
        check("first_act",  64'(d_act), 64'd1);
        check("first_fs",   64'(d_fs), 64'd1);
        check("small_first", 64'({s_x, s_y, s_act, s_fs}), 64'({11'd1, 10'd1, 1'b1, 1'b1}));
      end
      if (run == 0) begin
        if (e == 1) check("fast_first_x", 64'({f_stb, f_x}), 64'({1'b1, 11'd1}));
        if (e == 5) check("x_hold", 64'({d_stb, d_x}), 64'({1'b0, 11'd1}));
        if (e == 2560) check("x_last_active", 64'(d_x), 64'd640);
        if (e == 2564) check("x_blank", 64'({d_x, d_act}), 64'd0);
        if (e == 2627) check("hs_before_sync", 64'(d_hs), 64'd1);
        if (e == 2628) check("hs_sync_start", 64'(d_hs), 64'd0);
        if (e == 3011) check("hs_sync_end", 64'(d_hs), 64'd0);
        if (e == 3012) check("hs_after_sync", 64'(d_hs), 64'd1);
        if (e == 3203) begin
          check("hs_low_clocks", 64'(d_hs_low), 64'd384);
          check("line_strobes",  64'(d_stb_n), 64'd800);
        end
        if (e == 3204) check("next_line", 64'({d_x, d_y, d_fs}), 64'({11'd1, 10'd2, 1'b0}));
        if (e == 3200) check("fast_hs_high_clocks", 64'(f_hs_high), 64'd384);
        if (e == 1251) check("small_vs_low_clocks", 64'(s_vs_low), 64'd192);
        if (e == 768)  check("small_y_last_line", 64'({s_x, s_y}), 64'({11'd0, 10'd8}));
        if (e == 772)  check("small_y_vblank", 64'({s_x, s_y, s_act}), 64'd0);
`ifdef VGA_TESTPAT_EN
        if (e == 4)    check("tp_x1",   64'(d_rgb), 64'h000);
        if (e == 324)  check("tp_x81",  64'({d_x, d_rgb}), 64'({11'd81, 12'h00F}));
        if (e == 2560) check("tp_x640", 64'(d_rgb), 64'hFFF);
        if (e == 2800) check("tp_blank", 64'(d_rgb), 64'h000);
`endif
      end
    end
    check("fast_stb_always", 64'(f_stb_n), 64'(n));
  endtask

  initial begin
    bit found;
    int p;
    rst_n = 1'b0;
    repeat (3) tick();
    e = 0;
    check("rst_x",   64'(d_x), 64'd0);
    check("rst_y",   64'(d_y), 64'd0);
    check("rst_flags", 64'({d_act, d_stb, d_fs}), 64'd0);
    check("rst_syncs_low", 64'({d_hs, d_vs}), 64'b11);
    check("rst_syncs_high", 64'({f_hs, f_vs, f_stb}), 64'd0);

    rst_n = 1'b1;
    run_trace(10500, 0);

    // Walk the small frame to h=5, v=4, then pulse reset for one edge.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      p = e / 4 - 1;
      if (e % 4 == 0 && p % 24 == 5 && (p / 24) % 13 == 4) found = 1'b1;
    end
    check("mid_reset_wait", 64'(found), 64'd1);
    check("mid_position", 64'({s_x, s_y, s_act}), 64'({11'd6, 10'd5, 1'b1}));
    rst_n = 1'b0;
    tick();
    check("mid_rst_coords", 64'({s_x, s_y}), 64'd0);
    check("mid_rst_flags",  64'({s_act, s_stb, s_fs}), 64'd0);
    check("mid_rst_syncs",  64'({s_hs, s_vs, d_hs, d_vs, f_hs, f_vs}), 64'b111100);
    rst_n = 1'b1;
    e = 0;
    run_trace(1300, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
